alu_muldiv: RTL and testbench

//   Parametrised successor ALU for the MIPS datapath: single-cycle combinational ops (same aluCtr codes)

---
 rtl/alu_muldiv.sv | 207 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//   EX-stage ALU for the MIPS datapath. A single-cycle combinational ALU
//   (selected by alu_ctr) sits beside an iterative radix-2 multiply/divide
//   unit that owns the architectural HI/LO registers. The hazard logic stalls
//   the pipeline while busy is high.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_a, in_b   operands (in_a also supplies shift amount / dividend / MTxx data)
//   alu_ctr      combinational operation select
//   md_op        mult/div/move-to operation, sampled with md_start
//   md_start     one-cycle request strobe
//   alu_res      combinational result; zero / overflow flags derived from it
//   hi, lo       HI/LO registers
//   busy         multiply/divide in progress
//   done         one-cycle pulse: hi/lo just written by a multiply/divide
//   div_by_zero  last completed DIV/DIVU had a zero divisor
// -----------------------------------------------------------------------------
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [3:0]         alu_ctr,
  input  logic [2:0]         md_op,
  input  logic               md_start,
  output logic [WIDTH-1:0]   alu_res,
  output logic               zero,
  output logic               overflow,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  // One extra count bit: values 0..WIDTH-1 are the radix-2 steps, WIDTH is the
  // write-back cycle that stores the result into hi/lo.
  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  // ---------------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum_ab, diff_ab;

  assign shamt   = in_a[SHAMT_W-1:0];
  assign sum_ab  = in_a + in_b;
  assign diff_ab = in_a - in_b;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned (latch).
    alu_res  = '0;
    overflow = 1'b0;
    case (alu_ctr)
      4'b0000: alu_res = in_a & in_b;
      4'b0001: alu_res = in_a | in_b;
      4'b0010: begin
        alu_res  = sum_ab;
        overflow = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_ab[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res  = diff_ab;
        overflow = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_ab[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'b1111: alu_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      4'b0011: alu_res = in_b << shamt;
      4'b0100: alu_res = in_b >> shamt;
      4'b1000: alu_res = $signed(in_b) >>> shamt;
      4'b1001: alu_res = in_a ^ in_b;
      4'b0101: alu_res = ~(in_a | in_b);
      4'b1010: alu_res = sum_ab;
      4'b1110: alu_res = diff_ab;
      4'b1100: alu_res = in_b << (WIDTH / 2);
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  // ---------------------------------------------------------------------------
  // Multiply / divide unit
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_q;     // partial product high half / partial remainder
  logic [WIDTH-1:0] q_q;       // multiplier (shifts out) / dividend -> quotient
  logic [WIDTH-1:0] m_q;       // multiplicand / divisor magnitude
  logic             is_div_q, neg_q_q, neg_r_q;

  logic             accept, op_mul, op_div, signed_op, a_neg, b_neg;
  logic             start_calc, start_dbz;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign accept     = md_start && (state_q != CALC);
  assign op_mul     = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign op_div     = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign signed_op  = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign a_neg      = signed_op && in_a[WIDTH-1];
  assign b_neg      = signed_op && in_b[WIDTH-1];
  assign mag_a      = a_neg ? -in_a : in_a;
  assign mag_b      = b_neg ? -in_b : in_b;
  assign start_dbz  = accept && op_div && (in_b == '0);
  assign start_calc = accept && (op_mul || (op_div && (in_b != '0)));

  // Step datapath: shift-add for multiply, restoring subtract for divide.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  assign mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (q_q[0] ? {1'b0, m_q} : '0);
  assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};   // msb set = borrow, keep shifted value
  assign prod      = neg_q_q ? -{acc_q[WIDTH-1:0], q_q} : {acc_q[WIDTH-1:0], q_q};
  assign quot      = neg_q_q ? -q_q : q_q;      // most-negative / -1 wraps naturally
  assign rem       = neg_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_calc)     state_d = CALC;
        else if (start_dbz) state_d = DONE;
        else                state_d = IDLE;
      end
      CALC:    if (cnt_q == CNT_W'(WIDTH)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      m_q         <= '0;
      is_div_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      if (state_q == CALC) begin
        if (cnt_q != CNT_W'(WIDTH)) begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            if (div_diff[WIDTH]) acc_q <= div_shift;
            else                 acc_q <= div_diff;
            q_q <= {q_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_q <= {1'b0, mul_sum[WIDTH:1]};
            q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
          end
        end else begin
          div_by_zero <= 1'b0;
          if (is_div_q) begin
            hi <= rem;
            lo <= quot;
          end else begin
            {hi, lo} <= prod;
          end
        end
      end else begin
        if (start_calc) begin
          cnt_q    <= '0;
          acc_q    <= '0;
          is_div_q <= op_div;
          neg_q_q  <= a_neg ^ b_neg;
          neg_r_q  <= a_neg;
          q_q      <= op_div ? mag_a : mag_b;
          m_q      <= op_div ? mag_b : mag_a;
        end
        if (start_dbz) begin
          hi          <= in_a;
          lo          <= '1;
          div_by_zero <= 1'b1;
        end
        if (accept && md_op == MD_MTHI) hi <= in_a;
        if (accept && md_op == MD_MTLO) lo <= in_a;
      end
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv
//   Directed self-checking bench for alu_muldiv (WIDTH=32). Inputs change on
//   the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_a, in_b;
  logic [3:0]   alu_ctr;
  logic [2:0]   md_op;
  logic         md_start;
  logic [W-1:0] alu_res, hi, lo;
  logic         zero, overflow, busy, done, div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .alu_ctr(alu_ctr),
    .md_op(md_op), .md_start(md_start), .alu_res(alu_res), .zero(zero),
    .overflow(overflow), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Combinational ALU vector: checks {overflow, zero, alu_res} together.
  task automatic alu_chk(input string tag, input logic [3:0] ctr, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic exp_ovf, input logic exp_zero);
    alu_ctr = ctr; in_a = a; in_b = b;
    #1;
    check(tag, {30'd0, overflow, zero, alu_res}, {30'd0, exp_ovf, exp_zero, exp_res});
  endtask

  // One-cycle request; returns on the falling edge after the request edge.
  task automatic start_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    md_op = op; in_a = a; in_b = b; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'b000;
  endtask

  // Full mult/div transaction: latency, busy coverage, result, flag, single done.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_cyc, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz);
    int cyc;
    int n_busy;
    start_md(op, a, b);
    cyc = 0; n_busy = 0;
    while (!done && cyc < 200) begin
      if (busy) n_busy++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_busy_cycles"}, n_busy, exp_cyc);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    check({tag, "_dbz"}, div_by_zero, exp_dbz);
    @(negedge clk);
    check({tag, "_done_once"}, done, 1'b0);
    check({tag, "_hilo_hold"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int cyc;
    int n_done;
    rst_n = 1'b0; in_a = '0; in_b = '0; alu_ctr = 4'b0000; md_op = 3'b000; md_start = 1'b0;
    #12;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {busy, done, div_by_zero}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // T1 and further combinational vectors
    alu_chk("add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b1, 1'b0);
    alu_chk("sub_zero",  4'b0110, 32'h5,         32'h5,          32'h0,         1'b0, 1'b1);
    alu_chk("sub_ovf",   4'b0110, 32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 1'b1, 1'b0);
    alu_chk("addu",      4'b1010, 32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1'b0);
    alu_chk("subu",      4'b1110, 32'h0,         32'h1,          32'hFFFF_FFFF, 1'b0, 1'b0);
    alu_chk("and",       4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b0);
    alu_chk("or",        4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hFFF0_FFF0, 1'b0, 1'b0);
    alu_chk("xor",       4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0, 1'b0);
    alu_chk("nor",       4'b0101, 32'h0,         32'h0,          32'hFFFF_FFFF, 1'b0, 1'b0);
    alu_chk("slt",       4'b0111, 32'hFFFF_FFFF, 32'h1,          32'h1,         1'b0, 1'b0);
    alu_chk("sltu",      4'b1111, 32'hFFFF_FFFF, 32'h1,          32'h0,         1'b0, 1'b1);
    alu_chk("sll_mask",  4'b0011, 32'h24,        32'h1,          32'h10,        1'b0, 1'b0);
    alu_chk("srl",       4'b0100, 32'h4,         32'h8000_0000,  32'h0800_0000, 1'b0, 1'b0);
    alu_chk("sra",       4'b1000, 32'h4,         32'h8000_0000,  32'hF800_0000, 1'b0, 1'b0);
    alu_chk("lui",       4'b1100, 32'h0,         32'h1234,       32'h1234_0000, 1'b0, 1'b0);
    alu_chk("undef",     4'b1011, 32'h7FFF_FFFF, 32'h1,          32'h0,         1'b0, 1'b1);

    // T2 multiply
    run_md("mult_neg",  3'b001, 32'hFFFF_FFFE, 32'h3, W + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_md("multu",     3'b010, 32'hFFFF_FFFE, 32'h3, W + 1, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);

    // T3 divide
    run_md("div_neg",   3'b011, 32'hFFFF_FFF9, 32'h2, W + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md("divu",      3'b100, 32'h7,         32'h2, W + 1, 32'h1,         32'h3,         1'b0);
    run_md("div_wrap",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, 32'h0, 32'h8000_0000, 1'b0);

    // T4 divide by zero, then a normal completion clears the flag
    run_md("divu_zero", 3'b100, 32'h9, 32'h0, 0, 32'h9, 32'hFFFF_FFFF, 1'b1);
    run_md("dbz_clear", 3'b100, 32'h7, 32'h2, W + 1, 32'h1, 32'h3, 1'b0);

    // MTHI direct write
    start_md(3'b101, 32'h55, 32'h0);
    check("mthi", {hi, done, busy}, {32'h55, 1'b0, 1'b0});

    // T5 request during busy is dropped; MTLO after completion gives no done
    start_md(3'b001, 32'hFFFF_FFFE, 32'h3);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (cyc == 5) begin
        md_start = 1'b1; md_op = 3'b001; in_a = 32'h5; in_b = 32'h5;
      end else begin
        md_start = 1'b0; md_op = 3'b000;
      end
      @(negedge clk);
      cyc++;
    end
    check("busy_ignore_latency", cyc, W + 1);
    check("busy_ignore_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    start_md(3'b110, 32'hAA, 32'h0);
    check("mtlo_value", {hi, lo}, {32'hFFFF_FFFF, 32'h0000_00AA});
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    check("mtlo_no_done", n_done, 0);

    // T6 reset in the middle of CALC aborts
    start_md(3'b001, 32'h7, 32'h9);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_flags", {busy, done}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", n_done, 0);
    run_md("mult_after_rst", 3'b001, 32'h3, 32'h4, W + 1, 32'h0, 32'hC, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
